fault_injection_engine: RTL and testbench

Parametrised second-generation fault injector for the safety island's built-in self-test. It walks a configurable SRAM window and, per word: reads, corrupts, writes back, reads back, checks ECC detection, then restores the original word. Pass and fail counts go to the safety controller. It sits between the BIST sequencer and the safety-island SRAM port, alongside the lockstep, ECC and watchdog monitors.

---
 rtl/fault_inj_pkg.sv | 32 +++
 rtl/fault_corrupt_unit.sv | 54 +++++
 rtl/fault_injection_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_fault_injection_engine.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_inj_pkg.sv
// Shared types for the fault injection engine.
//   fault_mode_t : decoded fault modes (stuck-at-0/1, bit-flip, rotate, cycle-by-index)
//   fie_state_t  : engine FSM states
package fault_inj_pkg;

  typedef enum logic [2:0] {
    ModeSa0   = 3'd0,
    ModeSa1   = 3'd1,
    ModeFlip  = 3'd2,
    ModeRot   = 3'd3,
    ModeCycle = 3'd4
  } fault_mode_t;

  typedef enum logic [3:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StChkReq,
    StChkWait,
    StDetect,
    StRestore,
    StNext,
    StDone
  } fie_state_t;

  // Busy covers every state that can own the SRAM port.
  function automatic logic state_is_busy(fie_state_t s);
    return !((s == StIdle) || (s == StDone));
  endfunction

endpackage

// File: rtl/fault_corrupt_unit.sv
// Combinational word corrupter.
//   data_i : original word        mask_i : base fault mask
//   mode_i : configured mode      idx_i  : test index (rotates mask, selects mode in cycle mode)
//   data_o : corrupted word       null_o : corrupted word equals original
// Rotate mode replaces the masked bits with the bits of the original word rotated right by one.
module fault_corrupt_unit
  import fault_inj_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IDX_WIDTH  = 16
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] mask_i,
  input  logic [2:0]            mode_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  null_o
);

  logic [31:0]           rot_amt;
  logic [DATA_WIDTH-1:0] mask_rot;
  logic [DATA_WIDTH-1:0] data_rotr;
  fault_mode_t           eff_mode;

  assign rot_amt   = 32'(idx_i) % DATA_WIDTH;
  // Shift by DATA_WIDTH yields zero, so rot_amt == 0 needs no special case.
  assign mask_rot  = (mask_i << rot_amt) | (mask_i >> (DATA_WIDTH - rot_amt));
  assign data_rotr = {data_i[0], data_i[DATA_WIDTH-1:1]};

  always_comb begin
    eff_mode = ModeFlip;
    case (mode_i)
      3'd0:    eff_mode = ModeSa0;
      3'd1:    eff_mode = ModeSa1;
      3'd2:    eff_mode = ModeFlip;
      3'd3:    eff_mode = ModeRot;
      3'd4:    eff_mode = fault_mode_t'({1'b0, idx_i[1:0]});
      default: eff_mode = ModeFlip;
    endcase
  end

  always_comb begin
    data_o = data_i ^ mask_rot;
    unique case (eff_mode)
      ModeSa0: data_o = data_i & ~mask_rot;
      ModeSa1: data_o = data_i | mask_rot;
      ModeRot: data_o = (data_i & ~mask_rot) | (data_rotr & mask_rot);
      default: data_o = data_i ^ mask_rot;
    endcase
  end

  assign null_o = (data_o == data_i);

endmodule

// File: rtl/fault_injection_engine.sv
// BIST fault injector: for each word of an SRAM window it reads, corrupts, writes back,
// reads back, checks for ECC detection and restores the original word.
//   clk_i, rst_i (sync, active-high)   enable_i : run request, low mid-run aborts
//   cfg_*     : mode, mask, base byte address, test count (captured at run start)
//   ecc_error_i : ECC monitor detection
//   sram_*    : req/gnt request channel, rvalid/rdata response channel
//   busy_o, done_o, pass_cnt_o, fail_cnt_o, fail_o : status and saturating results
module fault_injection_engine
  import fault_inj_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned DETECT_TIMEOUT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [2:0]              cfg_mode_i,
  input  logic [DATA_WIDTH-1:0]   cfg_mask_i,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr_i,
  input  logic [CNT_WIDTH-1:0]    cfg_num_tests_i,
  input  logic                    ecc_error_i,
  output logic                    sram_req_o,
  input  logic                    sram_gnt_i,
  output logic                    sram_we_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] sram_wstrb_o,
  input  logic                    sram_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    pass_cnt_o,
  output logic [CNT_WIDTH-1:0]    fail_cnt_o,
  output logic                    fail_o
);

  localparam int unsigned           StrbWidth = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WordBytes = ADDR_WIDTH'(StrbWidth);
  localparam int unsigned           TmoWidth  = $clog2(DETECT_TIMEOUT + 1);
  localparam logic [TmoWidth-1:0]   TmoLast   = TmoWidth'(DETECT_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]  CntMax    = {CNT_WIDTH{1'b1}};

  fie_state_t            state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] orig_q, orig_d;
  logic [DATA_WIDTH-1:0] corr_q, corr_d;
  logic [DATA_WIDTH-1:0] rdback_q, rdback_d;
  logic                  null_q, null_d;
  logic                  ecc_seen_q, ecc_seen_d;
  logic [TmoWidth-1:0]   tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  pass_q, pass_d;
  logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
  logic                  fail_flag_q, fail_flag_d;
  logic                  abort_q, abort_d;

  logic [DATA_WIDTH-1:0] corr_w;
  logic                  null_w;
  logic                  abort;
  logic                  test_pass;
  logic                  more_tests;

  fault_corrupt_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (CNT_WIDTH)
  ) u_corrupt (
    .data_i(sram_rdata_i),
    .mask_i(mask_q),
    .mode_i(mode_q),
    .idx_i (idx_q),
    .data_o(corr_w),
    .null_o(null_w)
  );

  // Once enable drops during a run the abort stays latched until IDLE.
  assign abort      = ~enable_i | abort_q;
  assign test_pass  = null_q ? ~ecc_seen_q : (ecc_seen_q && (rdback_q == corr_q));
  assign more_tests = ({1'b0, idx_q} + 1'b1) < {1'b0, num_q};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    num_d       = num_q;
    idx_d       = idx_q;
    orig_d      = orig_q;
    corr_d      = corr_q;
    rdback_d    = rdback_q;
    null_d      = null_q;
    ecc_seen_d  = ecc_seen_q;
    tmo_d       = tmo_q;
    pass_d      = pass_q;
    fail_cnt_d  = fail_cnt_q;
    fail_flag_d = fail_flag_q;
    abort_d     = abort_q | (~enable_i & state_is_busy(state_q));

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (enable_i) begin
          mode_d      = cfg_mode_i;
          mask_d      = cfg_mask_i;
          addr_d      = cfg_base_addr_i;
          num_d       = cfg_num_tests_i;
          idx_d       = '0;
          pass_d      = '0;
          fail_cnt_d  = '0;
          fail_flag_d = 1'b0;
          state_d     = (cfg_num_tests_i == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: begin
        // An ungranted read is withdrawn on abort: nothing outstanding, nothing modified.
        if (sram_gnt_i)  state_d = StRdWait;
        else if (abort)  state_d = StIdle;
      end
      StRdWait: begin
        ecc_seen_d = 1'b0;
        if (sram_rvalid_i) begin
          orig_d  = sram_rdata_i;
          corr_d  = corr_w;
          null_d  = null_w;
          state_d = abort ? StIdle : StWrReq;
        end
      end
      StWrReq: begin
        if (sram_gnt_i)  state_d = abort ? StRestore : StChkReq;
        else if (abort)  state_d = StIdle;
      end
      StChkReq: begin
        if (ecc_error_i) ecc_seen_d = 1'b1;
        if (sram_gnt_i)  state_d = StChkWait;
      end
      StChkWait: begin
        if (ecc_error_i) ecc_seen_d = 1'b1;
        if (sram_rvalid_i) begin
          rdback_d = sram_rdata_i;
          tmo_d    = '0;
          state_d  = abort ? StRestore : StDetect;
        end
      end
      StDetect: begin
        if (ecc_error_i) ecc_seen_d = 1'b1;
        tmo_d = tmo_q + 1'b1;
        // Detection is checked alongside expiry, so a coincident ecc_error_i is still counted.
        if (abort || ((ecc_error_i || ecc_seen_q) && !null_q) || (tmo_q == TmoLast)) begin
          state_d = StRestore;
        end
      end
      StRestore: begin
        if (sram_gnt_i) state_d = abort ? StIdle : StNext;
      end
      StNext: begin
        if (test_pass) begin
          if (pass_q != CntMax) pass_d = pass_q + 1'b1;
        end else begin
          if (fail_cnt_q != CntMax) fail_cnt_d = fail_cnt_q + 1'b1;
          fail_flag_d = 1'b1;
        end
        idx_d   = idx_q + 1'b1;
        addr_d  = addr_q + WordBytes;
        if (abort)           state_d = StIdle;
        else if (more_tests) state_d = StRdReq;
        else                 state_d = StDone;
      end
      StDone: begin
        if (!enable_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      mask_q      <= '0;
      addr_q      <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      orig_q      <= '0;
      corr_q      <= '0;
      rdback_q    <= '0;
      null_q      <= 1'b0;
      ecc_seen_q  <= 1'b0;
      tmo_q       <= '0;
      pass_q      <= '0;
      fail_cnt_q  <= '0;
      fail_flag_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      orig_q      <= orig_d;
      corr_q      <= corr_d;
      rdback_q    <= rdback_d;
      null_q      <= null_d;
      ecc_seen_q  <= ecc_seen_d;
      tmo_q       <= tmo_d;
      pass_q      <= pass_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_flag_q <= fail_flag_d;
      abort_q     <= abort_d;
    end
  end

  // Request fields come only from the state and registers, so they hold steady until grant.
  assign sram_req_o   = (state_q == StRdReq) || (state_q == StWrReq) ||
                        (state_q == StChkReq) || (state_q == StRestore);
  assign sram_we_o    = (state_q == StWrReq) || (state_q == StRestore);
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = (state_q == StWrReq)   ? corr_q :
                        (state_q == StRestore) ? orig_q : '0;
  assign sram_wstrb_o = sram_we_o ? {StrbWidth{1'b1}} : '0;
  assign busy_o       = state_is_busy(state_q);
  assign done_o       = (state_q == StDone);
  assign pass_cnt_o   = pass_q;
  assign fail_cnt_o   = fail_cnt_q;
  assign fail_o       = fail_flag_q;

endmodule

// File: tb/tb_fault_injection_engine.sv
module tb_fault_injection_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  cfg_mode = '0;
  logic [63:0] cfg_mask = '0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_num = '0;
  logic        ecc = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [63:0] rdata = '0;
  logic        sram_req_o, sram_we_o, busy_o, done_o, fail_o;
  logic [31:0] sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [7:0]  sram_wstrb_o;
  logic [15:0] pass_cnt_o, fail_cnt_o;

  fault_injection_engine #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .CNT_WIDTH(16), .DETECT_TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .cfg_mode_i(cfg_mode),
    .cfg_mask_i(cfg_mask), .cfg_base_addr_i(cfg_base), .cfg_num_tests_i(cfg_num),
    .ecc_error_i(ecc), .sram_req_o(sram_req_o), .sram_gnt_i(gnt), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_wstrb_o(sram_wstrb_o),
    .sram_rvalid_i(rvalid), .sram_rdata_i(rdata), .busy_o(busy_o), .done_o(done_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // SRAM + ECC model state
  logic [63:0] mem  [logic [31:0]];
  logic [63:0] gold [logic [31:0]];
  logic [31:0] wr_addr_log [$];
  logic [63:0] wr_data_log [$];
  int          wr_cnt, txn_cnt, viol;
  bit          rand_dly = 0;
  int          gnt_dly = 0, rd_dly = 0;
  bit          ecc_on = 0, spur_on = 0;
  logic [31:0] spur_addr = '0;
  bit          rd_pend = 0;
  logic [31:0] rd_addr;
  int          rd_cnt, gnt_cnt;
  bit          req_seen = 0;
  logic        l_we;
  logic [31:0] l_addr;
  logic [63:0] l_wdata;
  logic [7:0]  l_wstrb;

  initial begin
    forever begin
      bit outstanding;
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b0; ecc = 1'b0;
      if (rst) begin
        rd_pend = 0; req_seen = 0;
      end else begin
        outstanding = rd_pend;
        if (rd_pend) begin
          if (rd_cnt == 0) begin
            rvalid = 1'b1; rdata = mem[rd_addr]; rd_pend = 0;
            ecc = (ecc_on && (mem[rd_addr] !== gold[rd_addr])) ||
                  (spur_on && (rd_addr == spur_addr));
          end else rd_cnt--;
        end
        if (sram_req_o) begin
          if (outstanding) viol++;
          if (!req_seen) begin
            req_seen = 1; l_we = sram_we_o; l_addr = sram_addr_o;
            l_wdata = sram_wdata_o; l_wstrb = sram_wstrb_o;
            gnt_cnt = rand_dly ? int'($urandom_range(0, 7)) : gnt_dly;
          end else if (l_we !== sram_we_o || l_addr !== sram_addr_o ||
                       l_wdata !== sram_wdata_o || l_wstrb !== sram_wstrb_o) begin
            viol++;
          end
          if (!outstanding && gnt_cnt == 0) begin
            gnt = 1'b1; req_seen = 0; txn_cnt++;
            if (sram_we_o) begin
              if (sram_wstrb_o !== 8'hFF) viol++;
              mem[sram_addr_o] = sram_wdata_o;
              wr_addr_log.push_back(sram_addr_o);
              wr_data_log.push_back(sram_wdata_o);
              wr_cnt++;
            end else begin
              if (sram_wstrb_o !== 8'h00) viol++;
              rd_pend = 1; rd_addr = sram_addr_o;
              rd_cnt = rand_dly ? int'($urandom_range(0, 7)) : rd_dly;
            end
          end else if (gnt_cnt != 0) gnt_cnt--;
        end else req_seen = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic mem_init(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [63:0] v;
      a = base + 32'(i * 8);
      v = (i % 2 == 0) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
      mem[a] = v; gold[a] = v;
    end
  endtask

  task automatic mem_bad(input logic [31:0] base, input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i * 8);
      if (mem[a] !== gold[a]) bad++;
    end
  endtask

  task automatic clear_log();
    wr_addr_log.delete(); wr_data_log.delete();
    wr_cnt = 0; txn_cnt = 0; viol = 0;
  endtask

  task automatic start_run(input logic [2:0] m, input logic [63:0] mk,
                           input logic [31:0] b, input logic [15:0] n);
    cfg_mode = m; cfg_mask = mk; cfg_base = b; cfg_num = n; enable = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(posedge clk); #1;
      if (done_o) ok = 1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(posedge clk); #1;
      if (!busy_o && !done_o) ok = 1;
    end
  endtask

  task automatic end_run();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({sram_req_o, sram_we_o, busy_o, done_o, fail_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000",
                         {sram_req_o, sram_we_o, busy_o, done_o, fail_o}); end
    n_cmp++; if ({pass_cnt_o, fail_cnt_o} !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnts: got %h want 0", {pass_cnt_o, fail_cnt_o}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flip_pass();
    bit ok; int bad;
    mem_init(32'h100, 4); clear_log(); ecc_on = 1;
    start_run(3'd2, 64'h1, 32'h100, 16'd4);
    @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL flip_busy_start: got %b want 1", busy_o); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL flip_done: got timeout want done"); end
    n_cmp++; if (pass_cnt_o !== 16'd4 || fail_cnt_o !== 16'd0 || fail_o !== 1'b0) begin
      n_fail++; $display("FAIL flip_cnts: got p=%0d f=%0d fo=%b want p=4 f=0 fo=0",
                         pass_cnt_o, fail_cnt_o, fail_o); end
    n_cmp++; if (wr_cnt !== 8) begin
      n_fail++; $display("FAIL flip_wr_cnt: got %0d want 8", wr_cnt); end
    if (wr_cnt == 8) begin
      n_cmp++; if (wr_addr_log[0] !== 32'h100 || wr_addr_log[2] !== 32'h108 ||
                   wr_addr_log[4] !== 32'h110 || wr_addr_log[6] !== 32'h118) begin
        n_fail++; $display("FAIL flip_addrs: got %h %h %h %h want 100 108 110 118",
                           wr_addr_log[0], wr_addr_log[2], wr_addr_log[4], wr_addr_log[6]); end
      n_cmp++; if (wr_data_log[0] !== 64'h5555_5555_5555_5554 ||
                   wr_data_log[2] !== 64'hAAAA_AAAA_AAAA_AAA8) begin
        n_fail++; $display("FAIL flip_corrupt: got %h %h want 5555555555555554 aaaaaaaaaaaaaaa8",
                           wr_data_log[0], wr_data_log[2]); end
    end
    mem_bad(32'h100, 4, bad);
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL flip_restore: got %0d bad want 0", bad); end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL flip_proto: got %0d want 0", viol); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done_o !== 1'b1) begin
      n_fail++; $display("FAIL flip_done_hold: got %b want 1", done_o); end
    end_run();
    n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL flip_idle: got d=%b b=%b want 0 0", done_o, busy_o); end
    ecc_on = 0;
  endtask

  task automatic test_cycle_fail();
    bit ok; int bad;
    mem_init(32'h200, 8); clear_log(); ecc_on = 0;
    start_run(3'd4, 64'hFF, 32'h200, 16'd8);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL cycle_done: got timeout want done"); end
    n_cmp++; if (fail_cnt_o !== 16'd8 || pass_cnt_o !== 16'd0 || fail_o !== 1'b1) begin
      n_fail++; $display("FAIL cycle_cnts: got p=%0d f=%0d fo=%b want p=0 f=8 fo=1",
                         pass_cnt_o, fail_cnt_o, fail_o); end
    n_cmp++; if (wr_cnt !== 16) begin
      n_fail++; $display("FAIL cycle_wr_cnt: got %0d want 16", wr_cnt); end
    if (wr_cnt == 16) begin
      n_cmp++; if (wr_data_log[0] !== 64'h5555_5555_5555_5500) begin
        n_fail++; $display("FAIL cycle_sa0: got %h want 5555555555555500", wr_data_log[0]); end
      n_cmp++; if (wr_data_log[2] !== 64'hAAAA_AAAA_AAAA_ABFE) begin
        n_fail++; $display("FAIL cycle_sa1: got %h want aaaaaaaaaaaaabfe", wr_data_log[2]); end
      n_cmp++; if (wr_data_log[6] !== 64'hAAAA_AAAA_AAAA_AD52) begin
        n_fail++; $display("FAIL cycle_rot: got %h want aaaaaaaaaaaaad52", wr_data_log[6]); end
    end
    mem_bad(32'h200, 8, bad);
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL cycle_restore: got %0d bad want 0", bad); end
    end_run();
  endtask

  task automatic test_null();
    bit ok;
    mem_init(32'h300, 3); clear_log(); ecc_on = 0; spur_on = 0;
    start_run(3'd0, 64'h0, 32'h300, 16'd3);
    wait_done(ok);
    n_cmp++; if (!ok || pass_cnt_o !== 16'd3 || fail_cnt_o !== 16'd0 || fail_o !== 1'b0) begin
      n_fail++; $display("FAIL null_clean: got ok=%b p=%0d f=%0d fo=%b want 1 3 0 0",
                         ok, pass_cnt_o, fail_cnt_o, fail_o); end
    end_run();
    clear_log(); spur_on = 1; spur_addr = 32'h308;
    start_run(3'd0, 64'h0, 32'h300, 16'd3);
    wait_done(ok);
    n_cmp++; if (!ok || pass_cnt_o !== 16'd2 || fail_cnt_o !== 16'd1 || fail_o !== 1'b1) begin
      n_fail++; $display("FAIL null_spurious: got ok=%b p=%0d f=%0d fo=%b want 1 2 1 1",
                         ok, pass_cnt_o, fail_cnt_o, fail_o); end
    end_run();
    spur_on = 0;
  endtask

  task automatic test_random_delays();
    bit ok; int bad;
    mem_init(32'h100, 4); clear_log(); ecc_on = 1; rand_dly = 1;
    start_run(3'd2, 64'h1, 32'h100, 16'd4);
    wait_done(ok);
    n_cmp++; if (!ok || pass_cnt_o !== 16'd4 || fail_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL rand_cnts: got ok=%b p=%0d f=%0d want 1 4 0",
                         ok, pass_cnt_o, fail_cnt_o); end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL rand_proto: got %0d want 0", viol); end
    n_cmp++; if (wr_cnt !== 8 || txn_cnt !== 16) begin
      n_fail++; $display("FAIL rand_txns: got wr=%0d all=%0d want 8 16", wr_cnt, txn_cnt); end
    mem_bad(32'h100, 4, bad);
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rand_restore: got %0d bad want 0", bad); end
    end_run();
    rand_dly = 0; ecc_on = 0;
  endtask

  task automatic test_abort_chk();
    bit hit, ok; int bad;
    mem_init(32'h100, 4); clear_log(); ecc_on = 1; rd_dly = 4;
    start_run(3'd2, 64'h1, 32'h100, 16'd4);
    hit = 0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk); #1;
      if (wr_cnt == 5 && rd_pend) hit = 1;
    end
    enable = 1'b0;
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL abort_chk_reach: got timeout want chk read"); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_chk_idle: got busy want idle"); end
    n_cmp++; if (wr_cnt !== 6) begin
      n_fail++; $display("FAIL abort_chk_wr_cnt: got %0d want 6", wr_cnt); end
    if (wr_cnt == 6) begin
      n_cmp++; if (wr_addr_log[5] !== 32'h110 || wr_data_log[5] !== 64'h5555_5555_5555_5555) begin
        n_fail++; $display("FAIL abort_chk_restore_wr: got %h/%h want 110/5555555555555555",
                           wr_addr_log[5], wr_data_log[5]); end
    end
    n_cmp++; if (pass_cnt_o !== 16'd2 || fail_cnt_o !== 16'd0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_chk_cnts: got p=%0d f=%0d d=%b want 2 0 0",
                         pass_cnt_o, fail_cnt_o, done_o); end
    mem_bad(32'h100, 4, bad);
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL abort_chk_mem: got %0d bad want 0", bad); end
    ecc_on = 0; rd_dly = 0;
  endtask

  task automatic test_abort_rd();
    bit hit, ok;
    mem_init(32'h400, 3); clear_log(); rd_dly = 4;
    start_run(3'd2, 64'h1, 32'h400, 16'd3);
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk); #1;
      if (rd_pend && wr_cnt == 0) hit = 1;
    end
    enable = 1'b0;
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL abort_rd_reach: got timeout want read"); end
    wait_idle(ok);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (!ok || wr_cnt !== 0 || txn_cnt !== 1) begin
      n_fail++; $display("FAIL abort_rd_traffic: got ok=%b wr=%0d all=%0d want 1 0 1",
                         ok, wr_cnt, txn_cnt); end
    n_cmp++; if (pass_cnt_o !== 16'd0 || fail_cnt_o !== 16'd0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_rd_state: got p=%0d f=%0d b=%b want 0 0 0",
                         pass_cnt_o, fail_cnt_o, busy_o); end
    rd_dly = 0;
  endtask

  task automatic test_wrap();
    bit ok;
    mem_init(32'hFFFF_FFF8, 2); clear_log(); ecc_on = 1;
    start_run(3'd2, 64'h1, 32'hFFFF_FFF8, 16'd2);
    wait_done(ok);
    n_cmp++; if (!ok || pass_cnt_o !== 16'd2 || wr_cnt !== 4) begin
      n_fail++; $display("FAIL wrap_run: got ok=%b p=%0d wr=%0d want 1 2 4", ok, pass_cnt_o, wr_cnt);
    end
    if (wr_cnt == 4) begin
      n_cmp++; if (wr_addr_log[0] !== 32'hFFFF_FFF8 || wr_addr_log[2] !== 32'h0) begin
        n_fail++; $display("FAIL wrap_addr: got %h %h want fffffff8 0",
                           wr_addr_log[0], wr_addr_log[2]); end
    end
    end_run();
    ecc_on = 0;
  endtask

  task automatic test_zero_tests();
    clear_log();
    start_run(3'd2, 64'h1, 32'h100, 16'd0);
    @(posedge clk); #1;
    n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got d=%b b=%b want 1 0", done_o, busy_o); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (txn_cnt !== 0 || done_o !== 1'b1) begin
      n_fail++; $display("FAIL zero_traffic: got txn=%0d d=%b want 0 1", txn_cnt, done_o); end
    end_run();
  endtask

  task automatic test_mid_reset();
    bit hit;
    mem_init(32'h100, 4); clear_log(); ecc_on = 1;
    start_run(3'd2, 64'h1, 32'h100, 16'd4);
    hit = 0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk); #1;
      if (wr_cnt >= 3) hit = 1;
    end
    n_cmp++; if (!hit || pass_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL midrst_reach: got hit=%b p=%0d want 1 1", hit, pass_cnt_o); end
    rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({sram_req_o, sram_we_o, busy_o, done_o, fail_o} !== 5'b0 ||
                 sram_addr_o !== 32'h0 || sram_wdata_o !== 64'h0 || sram_wstrb_o !== 8'h0 ||
                 pass_cnt_o !== 16'h0 || fail_cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got r=%b a=%h p=%0d b=%b want all zero",
                         sram_req_o, sram_addr_o, pass_cnt_o, busy_o); end
    rst = 1'b0; ecc_on = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_flip_pass();
    test_cycle_fail();
    test_null();
    test_random_delays();
    test_abort_chk();
    test_abort_rd();
    test_wrap();
    test_zero_tests();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
